// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, debounces press
// and release of a single key, and strobes its hex code once per press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] PRESS_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // The HELD cycle that first sees the key up is the first of the release run.
  localparam logic [CW-1:0] REL_LAST   = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t        state;
  logic [1:0]    row_idx, col_idx;
  logic [DW-1:0] dwell;
  logic [CW-1:0] db_cnt;
  logic          one_low, key_only, key_up;

  function automatic logic [1:0] low_idx(input logic [3:0] c);
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!c[i]) low_idx = 2'(i);
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    key_map = 4'h0;
    case ({r, c})
      4'h0: key_map = 4'h1;
      4'h1: key_map = 4'h2;
      4'h2: key_map = 4'h3;
      4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;
      4'h5: key_map = 4'h5;
      4'h6: key_map = 4'h6;
      4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;
      4'h9: key_map = 4'h8;
      4'hA: key_map = 4'h9;
      4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;
      4'hD: key_map = 4'h0;
      4'hE: key_map = 4'hF;
      4'hF: key_map = 4'hD;
      default: key_map = 4'h0;
    endcase
  endfunction

  assign one_low  = ($countones(~col) == 1);
  assign key_only = (col == ~(4'b0001 << col_idx));
  assign key_up   = col[col_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      row       <= 4'b1110;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      dwell     <= '0;
      db_cnt    <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            if (one_low) begin
              col_idx <= low_idx(col);
              db_cnt  <= '0;
              state   <= PRESS_DB;
            end else begin
              row     <= {row[2:0], row[3]};
              row_idx <= row_idx + 2'd1;
              dwell   <= '0;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        PRESS_DB: begin
          if (key_only) begin
            if (db_cnt == PRESS_LAST) begin
              key_code  <= key_map(row_idx, col_idx);
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= HELD;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            row     <= {row[2:0], row[3]};
            row_idx <= row_idx + 2'd1;
            dwell   <= '0;
            state   <= SCAN;
          end
        end
        HELD: begin
          // Only the latched column matters here; other keys are ignored.
          if (key_up) begin
            db_cnt <= '0;
            state  <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (key_up) begin
            if (db_cnt == REL_LAST) begin
              key_held <= 1'b0;
              row      <= {row[2:0], row[3]};
              row_idx  <= row_idx + 2'd1;
              dwell    <= '0;
              state    <= SCAN;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            db_cnt <= '0;
            state  <= HELD;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives col from row and a
// set of pressed keys; expectations come from key-level rules.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int D  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col = 4'hF;
  logic [3:0] row, key_code;
  logic       key_valid, key_held;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .col(col), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         key;
    int         hold;
    int         exp_n;
    logic [3:0] exp_code;
  } vec_t;

  logic [3:0]  kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0]  rows [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int          checks = 0, errors = 0, strobes = 0;
  logic [15:0] keys = '0;
  logic        mon_en = 1'b0, prev_valid = 1'b0;
  logic [3:0]  prev_code = 4'h0;

  function automatic logic [3:0] col_fn(input logic [3:0] r, input logic [15:0] k);
    logic [3:0] c = 4'hF;
    for (int j = 0; j < 4; j++)
      if (!r[j])
        for (int i = 0; i < 4; i++)
          if (k[j*4+i]) c[i] = 1'b0;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive col for the coming edge, then observe at the following negedge.
  task automatic tick();
    col = col_fn(row, keys);
    @(negedge clk);
    if (key_valid) strobes++;
    if (mon_en) begin
      checks++;
      if ((key_valid && prev_valid) || (!key_valid && key_code !== prev_code)) begin
        errors++;
        $display("FAIL strobe_rules valid=%0b prev_valid=%0b code=%0h prev_code=%0h",
                 key_valid, prev_valid, key_code, prev_code);
      end
    end
    prev_valid = key_valid;
    prev_code  = key_code;
    mon_en     = 1'b1;
  endtask

  task automatic wait_row(input logic [3:0] r, input int max);
    int n = 0;
    while (row !== r && n < max) begin tick(); n++; end
    chk("wait_row", row, r);
  endtask

  task automatic wait_strobe(input int max, output int n);
    int s0 = strobes;
    n = 0;
    while (strobes == s0 && n < max) begin tick(); n++; end
    chk("wait_strobe", (strobes != s0), 1);
  endtask

  initial begin
    vec_t vt [8];
    int   n;
    logic [3:0] exp_code;

    vt[0] = '{13, 50, 1, 4'h0};
    vt[1] = '{3,  50, 1, 4'hA};
    vt[2] = '{12, 5,  0, 4'hA};
    vt[3] = '{15, 50, 1, 4'hD};
    vt[4] = '{0,  50, 1, 4'h1};
    vt[5] = '{14, 50, 1, 4'hF};
    vt[6] = '{10, 50, 1, 4'h9};
    vt[7] = '{7,  50, 1, 4'hB};

    // Reset and idle rotation
    repeat (2) @(negedge clk);
    chk("rst_row", row, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_held", key_held, 0);
    reset = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      tick();
      if (j % 4 == 3) chk("idle_row_hold", row, rows[(j/4)%4]);
      if (j % 4 == 0) chk("idle_row_step", row, rows[(j/4)%4]);
    end

    // Clean "5": latency from row arrival, single strobe, release timing
    strobes = 0;
    keys = 16'd1 << 5;
    wait_row(4'b1101, 20);
    wait_strobe(30, n);
    chk("press_latency", n, SD + D);
    chk("code_5", key_code, 4'h5);
    chk("held_5", key_held, 1);
    repeat (40) tick();
    chk("one_strobe_5", strobes, 1);
    chk("held_long_5", key_held, 1);
    chk("row_kept_5", row, 4'b1101);
    keys = '0;
    repeat (7) tick();
    chk("held_in_release_db", key_held, 1);
    tick();
    chk("released_5", key_held, 0);
    chk("resume_row", row, 4'b1011);

    // Table of clean and too-short presses
    for (int v = 0; v < 8; v++) begin
      strobes = 0;
      keys = 16'd1 << vt[v].key;
      repeat (vt[v].hold) tick();
      keys = '0;
      repeat (25) tick();
      chk($sformatf("vec%0d_strobes", v), strobes, vt[v].exp_n);
      chk($sformatf("vec%0d_code", v), key_code, vt[v].exp_code);
      chk($sformatf("vec%0d_held", v), key_held, 0);
    end

    // Bouncing "9"
    strobes = 0;
    repeat (10) begin
      keys = 16'd1 << 10; repeat (3) tick();
      keys = '0;          repeat (3) tick();
    end
    chk("bounce_no_strobe", strobes, 0);
    keys = 16'd1 << 10;
    wait_strobe(40, n);
    chk("bounce_code_9", key_code, 4'h9);
    repeat (8) tick();
    chk("bounce_one_strobe", strobes, 1);
    keys = '0;
    repeat (25) tick();
    chk("bounce_released", key_held, 0);

    // Two keys on row 3: ghost rejected, scanning moves on
    strobes = 0;
    keys = (16'd1 << 12) | (16'd1 << 13);
    wait_row(4'b0111, 20);
    repeat (4) tick();
    chk("multi_row_adv", row, 4'b1110);
    repeat (20) tick();
    chk("multi_no_strobe", strobes, 0);
    keys = '0;
    repeat (5) tick();

    // "0" held, then A and E added: first key wins
    strobes = 0;
    keys = 16'd1 << 13;
    wait_strobe(40, n);
    chk("code_0", key_code, 4'h0);
    keys = keys | (16'd1 << 3) | (16'd1 << 12);
    repeat (30) tick();
    chk("first_wins_strobes", strobes, 1);
    chk("first_wins_code", key_code, 4'h0);
    chk("first_wins_held", key_held, 1);
    keys = '0;
    repeat (25) tick();
    chk("first_wins_released", key_held, 0);

    // "D" with a 3-cycle release glitch
    strobes = 0;
    keys = 16'd1 << 15;
    wait_strobe(40, n);
    repeat (10) tick();
    keys = '0;
    repeat (3) tick();
    keys = 16'd1 << 15;
    repeat (10) tick();
    chk("glitch_held", key_held, 1);
    chk("glitch_strobes", strobes, 1);
    chk("glitch_code", key_code, 4'hD);
    keys = '0;
    repeat (7) tick();
    chk("glitch_rel_pending", key_held, 1);
    tick();
    chk("glitch_released", key_held, 0);

    // Async reset while "F" is held
    strobes = 0;
    keys = 16'd1 << 14;
    wait_strobe(40, n);
    repeat (5) tick();
    chk("f_held", key_held, 1);
    #2;
    reset = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("arst_row", row, 4'b1110);
    chk("arst_held", key_held, 0);
    chk("arst_valid", key_valid, 0);
    chk("arst_code", key_code, 0);
    keys = '0;
    repeat (3) tick();
    chk("arst_strobes", strobes, 1);
    reset = 1'b0;
    repeat (5) tick();

    // Random presses with taps and same-row ghosts against a key-level model
    exp_code = 4'h0;
    for (int it = 0; it < 20; it++) begin
      int key   = $urandom_range(0, 15);
      bit multi = ($urandom_range(0, 3) == 0);
      int k2    = (key & ~3) | ((key + 1 + $urandom_range(0, 2)) & 3);
      int taps  = $urandom_range(0, 3);
      strobes = 0;
      for (int t = 0; t < taps; t++) begin
        keys = 16'd1 << key;
        repeat ($urandom_range(1, 3)) tick();
        keys = '0;
        repeat ($urandom_range(2, 5)) tick();
      end
      keys = (16'd1 << key) | (multi ? (16'd1 << k2) : 16'd0);
      repeat ($urandom_range(40, 70)) tick();
      keys = '0;
      repeat ($urandom_range(25, 40)) tick();
      if (!multi) exp_code = kmap[key];
      chk($sformatf("rnd%0d_strobes", it), strobes, multi ? 0 : 1);
      chk($sformatf("rnd%0d_code", it), key_code, exp_code);
      chk($sformatf("rnd%0d_held", it), key_held, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad. Drives one row low at a time and reads the synchronized, active-low column bus from the column synchronizer stage.
- Debounces both press and release.
- Emits a one-cycle key_valid strobe with a 4-bit hex key code per debounced press; only one key is accepted at a time.
- Sits between the column synchronizer and the key-history/display logic.

Parameters:
- SCAN_DIV, 4, clk cycles each row is driven before col is sampled; must be >= 3 to cover the 2-cycle synchronizer latency.
- DEBOUNCE_CYCLES, 8, consecutive stable clk cycles required to accept a press or a release; must be >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- col  input  4  synchronized column levels, active-low; bit i = column i.
- row  output  4  row drive, active-low one-hot; bit j = row j.
- key_code  output  4  hex code of the last accepted key; holds its value between presses.
- key_valid  output  1  one-cycle pulse when key_code is updated.
- key_held  output  1  high while an accepted key is still pressed (through release debounce).

Behaviour:
- Reset (async, active-high): state=SCAN, row=4'b1110, dwell/debounce counters=0, key_code=4'h0, key_valid=0, key_held=0. Reset mid-debounce or mid-hold discards the key with no strobe.
- Key map, row j / col i:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- States: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN:
  - Drive the current row and count dwell cycles 0..SCAN_DIV-1.
  - On dwell=SCAN_DIV-1, sample col:
    - Exactly one bit low: latch row index and col index, clear the debounce counter, go to PRESS_DB. The row stays driven.
    - No bit low, or more than one bit low (ghosting/multi-press): rotate row to the next index (3 wraps to 0), clear dwell, stay in SCAN.
- PRESS_DB:
  - Each cycle the latched col bit is low and all other col bits are high, increment the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the condition still true: next cycle key_code=map(row,col), key_valid=1 for exactly that cycle, key_held=1, go to HELD.
  - Any cycle the condition fails: return to SCAN on the next row, dwell=0, no strobe.
- HELD:
  - Row stays driven and key_held=1.
  - Other columns going low are ignored (first key wins).
  - Latched col bit high: clear the counter, go to RELEASE_DB.
- RELEASE_DB:
  - Latched col bit high for DEBOUNCE_CYCLES consecutive cycles: key_held=0, go to SCAN on the next row, dwell=0.
  - Latched col bit low at any point: return to HELD; the counter clears and there is no new strobe.
- Throughput: one key_valid per press-release cycle; holding a key never re-strobes.
- key_valid is never asserted on two consecutive cycles.
- key_code changes only in the cycle key_valid=1.
- Latency from the first low sample to key_valid: DEBOUNCE_CYCLES+1 clk.
- Counters are sized to $clog2 of their parameter and never overflow: they saturate by state exit.

Test Plan:
- Reset and idle (SCAN_DIV=4, DEBOUNCE_CYCLES=8): assert reset with col=4'hF -> row=1110, key_valid=0, key_code=0. Release reset -> row rotates 1110,1101,1011,0111,1110 every 4 cycles.
- Clean press of "5" (col[1] low only while row=1101, held 50 cycles) -> exactly one key_valid pulse with key_code=4'h5. key_held=1 until 8 cycles after col[1] rises. Scanning then resumes on row=1011.
- Bounce: press "9" with col[2] toggling low for 3 cycles then high, repeated -> no key_valid. Then stable low 8 cycles -> single key_valid, key_code=4'h9.
- Multi-key: col=4'b1100 on row=0111 -> no strobe, row advances. While "0" is held, pressing "A" -> no second strobe; key_code stays 4'h0.
- Release bounce: hold "D", then a 3-cycle high glitch on col[3] -> key_held stays 1, no re-strobe. True release -> key_held=0 after 8 cycles.
- Async reset in HELD with key "F" held -> outputs return to reset values immediately (same cycle, asynchronously), row=1110, no key_valid.
